// File: rtl/reg_write_arbiter_if.sv
// Write-request bus between four requesters and the shared-register arbiter.
// The master side drives requests and data; the slave side returns grant and register state.
interface reg_write_arbiter_if #(
  parameter int W = 8
) ();
  logic [3:0]     req;
  logic [4*W-1:0] wdata;
  logic [3:0]     gnt;
  logic           wr_en;
  logic [1:0]     wr_src;
  logic [W-1:0]   q;
  logic           busy;

  modport master (
    output req, wdata,
    input  gnt, wr_en, wr_src, q, busy
  );

  modport slave (
    input  req, wdata,
    output gnt, wr_en, wr_src, q, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one of four requesters bursts of writes
// into a single shared register, with an IDLE gap between grants.
module reg_write_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk_amisha,
  input  logic          reset_amisha,
  reg_write_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e         state_q, state_d;
  logic [3:0]     gnt_q, gnt_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     own_q, own_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   q_q, q_d;

  logic [6:0]     req2;
  logic [3:0]     rot;
  logic [1:0]     off;
  logic [1:0]     sel;
  logic           wr_en;
  logic           rel;

  // Rotate requests so bit 0 is the requester at ptr.
  assign req2 = {bus.req[2:0], bus.req};
  assign rot  = req2[ptr_q +: 4];
  assign sel  = ptr_q + off;

  always_comb begin
    off = 2'd0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  assign wr_en = |(gnt_q & bus.req);
  assign rel   = !bus.req[own_q] ||
                 (wr_en && (cnt_q == LAST));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = 4'b0001 << sel;
          own_d   = sel;
          cnt_d   = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (wr_en) begin
          q_d   = bus.wdata[own_q*W +: W];
          cnt_d = cnt_q + CW'(1);
        end
        if (rel) begin
          gnt_d   = 4'b0000;
          ptr_d   = own_q + 2'd1;
          own_d   = 2'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      ptr_q   <= 2'd0;
      own_q   <= 2'd0;
      cnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.wr_en  = wr_en;
  assign bus.wr_src = own_q;
  assign bus.q      = q_q;
  assign bus.busy   = (state_q == OWN);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: MAX_BURST=4 instance plus a
// MAX_BURST=1 instance sharing clock and reset.
module tb_reg_write_arbiter;
  logic clk_amisha = 1'b0;
  logic reset_amisha = 1'b1;
  int checks = 0;
  int errors = 0;

  reg_write_arbiter_if #(.W(8)) bus ();
  reg_write_arbiter_if #(.W(8)) bus1 ();

  reg_write_arbiter #(.W(8), .MAX_BURST(4)) dut (
    .clk_amisha  (clk_amisha),
    .reset_amisha(reset_amisha),
    .bus         (bus)
  );

  reg_write_arbiter #(.W(8), .MAX_BURST(1)) dut1 (
    .clk_amisha  (clk_amisha),
    .reset_amisha(reset_amisha),
    .bus         (bus1)
  );

  always #5 clk_amisha = ~clk_amisha;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_amisha);
    #1;
  endtask

  initial begin
    bus.req    = 4'b0000;
    bus.wdata  = '0;
    bus1.req   = 4'b0000;
    bus1.wdata = '0;
    #2;
    chk("rst_gnt",   32'(bus.gnt), 32'h0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
    chk("rst_src",   32'(bus.wr_src), 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_q",     32'(bus.q), 32'h0);
    step();
    step();
    reset_amisha = 1'b0;

    // Single requester 2, held three cycles
    bus.req = 4'b0100;
    bus.wdata = 32'h00A5_0000;
    step();
    chk("a_gnt",   32'(bus.gnt), 32'h4);
    chk("a_src",   32'(bus.wr_src), 32'h2);
    chk("a_busy",  32'(bus.busy), 32'h1);
    chk("a_wr_en", 32'(bus.wr_en), 32'h1);
    chk("a_q0",    32'(bus.q), 32'h00);
    step();
    chk("a_q1",    32'(bus.q), 32'hA5);
    step();
    bus.req = 4'b0000;
    #1;
    chk("a_wr_off", 32'(bus.wr_en), 32'h0);
    step();
    chk("a_rel_gnt",  32'(bus.gnt), 32'h0);
    chk("a_rel_busy", 32'(bus.busy), 32'h0);
    chk("a_rel_src",  32'(bus.wr_src), 32'h0);
    chk("a_hold_q",   32'(bus.q), 32'hA5);

    // ptr is 3: requester 1 wins, requester 3 raised mid-burst
    bus.req = 4'b0010;
    bus.wdata = 32'hFF00_5A00;
    step();
    chk("c_gnt1", 32'(bus.gnt), 32'h2);
    step();
    chk("c_q1", 32'(bus.q), 32'h5A);
    bus.req = 4'b1010;
    step();
    chk("c_q2",   32'(bus.q), 32'h5A);
    chk("c_gnt2", 32'(bus.gnt), 32'h2);
    bus.req = 4'b1000;
    step();
    chk("c_rel",  32'(bus.gnt), 32'h0);
    chk("c_q3",   32'(bus.q), 32'h5A);
    step();
    chk("c_gnt3", 32'(bus.gnt), 32'h8);
    chk("c_src3", 32'(bus.wr_src), 32'h3);
    chk("c_q4",   32'(bus.q), 32'h5A);
    step();
    chk("c_qff",  32'(bus.q), 32'hFF);
    step();
    step();
    chk("c_w3_gnt", 32'(bus.gnt), 32'h8);
    step();
    chk("c_w4_gnt", 32'(bus.gnt), 32'h0);
    bus.req = 4'b0000;

    // Async reset mid-burst with q = 3C
    step();
    bus.req = 4'b0100;
    bus.wdata = 32'h003C_0000;
    step();
    chk("d_gnt", 32'(bus.gnt), 32'h4);
    step();
    chk("d_q", 32'(bus.q), 32'h3C);
    #2;
    reset_amisha = 1'b1;
    #1;
    chk("d_rst_q",    32'(bus.q), 32'h0);
    chk("d_rst_gnt",  32'(bus.gnt), 32'h0);
    chk("d_rst_wr",   32'(bus.wr_en), 32'h0);
    chk("d_rst_busy", 32'(bus.busy), 32'h0);
    step();
    reset_amisha = 1'b0;
    bus.req = 4'b1010;
    step();
    chk("d_first_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    step();
    chk("d_rel", 32'(bus.gnt), 32'h0);

    // All four requesting after a fresh reset
    reset_amisha = 1'b1;
    step();
    reset_amisha = 1'b0;
    bus.req = 4'b1111;
    bus.wdata = 32'h4433_2211;
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      logic [7:0] dat[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int g = 0; g < 5; g++) begin
        step();
        chk("b_gnt", 32'(bus.gnt), 32'(4'b0001 << order[g]));
        for (int w = 1; w <= 4; w++) begin
          step();
          chk("b_q", 32'(bus.q), 32'(dat[order[g]]));
          chk("b_gnt_w", 32'(bus.gnt),
              (w == 4) ? 32'h0 : 32'(4'b0001 << order[g]));
        end
      end
    end
    bus.req = 4'b0000;
    step();
    chk("b_idle", 32'(bus.gnt), 32'h0);

    // MAX_BURST = 1 instance, requesters 0 and 1 held
    bus1.req = 4'b0011;
    bus1.wdata = 32'h0000_B2B1;
    step();
    chk("e_g0", 32'(bus1.gnt), 32'h1);
    step();
    chk("e_q0", 32'(bus1.q), 32'hB1);
    chk("e_z0", 32'(bus1.gnt), 32'h0);
    step();
    chk("e_g1", 32'(bus1.gnt), 32'h2);
    step();
    chk("e_q1", 32'(bus1.q), 32'hB2);
    chk("e_z1", 32'(bus1.gnt), 32'h0);
    step();
    chk("e_g2", 32'(bus1.gnt), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
